// File: rtl/uart_apb_fifo.sv
// APB UART: baud generator, FIFO-backed TX engine and 16x-oversampled RX engine with parity and sticky errors.
// Define UART_APB_FIFO_LOOPBACK_EN to implement CTRL[8], which routes the TX line back into RX internally.
module uart_apb_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        irqreq,
  input  logic        rxd,
  output logic        txd
);
  // state  | meaning
  // IDLE   | line idle; TX waits for FIFO data, RX waits for a falling edge
  // START  | start bit (RX checks it at half a bit time)
  // DATA   | data bits, LSB first
  // PARITY | parity bit, only when par_en
  // STOP   | stop bit(s); RX pushes the character here
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_APB_FIFO_LOOPBACK_EN
  localparam int CTRL_W = 9;
`else
  localparam int CTRL_W = 8;
`endif
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

  logic [CTRL_W-1:0]    ctrl;
  logic [DIV_W-1:0]     div_q, baud_cnt;
  logic                 frame_err, parity_err, overrun, tx_ovf;
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp, rx_wp, rx_rp;
  uart_state_t          tx_state, rx_state;
  logic [4:0]           tx_tcnt;
  logic [3:0]           rx_tcnt, tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh;
  logic                 tx_par, tx_line, rx_s1, rx_s2, rx_s3, rx_src;

  wire tx_en = ctrl[0], rx_en = ctrl[1], par_en = ctrl[2], par_odd = ctrl[3];
  wire stop2 = ctrl[4], ie_rx = ctrl[5], ie_tx = ctrl[6], ie_err = ctrl[7];

  wire       acc     = PSEL & PENABLE;
  wire       addr_ok = (PADDR[31:4] == 28'd0);
  wire       wr_en   = acc & PWRITE & addr_ok;
  wire       rd_en   = acc & ~PWRITE & addr_ok;
  wire [1:0] sel     = PADDR[3:2];
  wire       stat_rd = rd_en && sel == 2'd1;
  logic      unused_ok;
  assign unused_ok = ^{PADDR[1:0], PWDATA};

  wire tx_empty  = tx_wp == tx_rp;
  wire tx_full   = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  wire rx_empty  = rx_wp == rx_rp;
  wire rx_full   = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  wire tx_busy   = tx_state != S_IDLE;
  wire tick      = baud_cnt == div_q;
  wire tx_tc     = tick && tx_tcnt == 5'd0;
  wire rx_tc     = tick && rx_tcnt == 4'd0;
  wire [DATA_BITS-1:0] tx_head = tx_mem[tx_rp[AW-1:0]];
  wire [DATA_BITS-1:0] rx_head = rx_mem[rx_rp[AW-1:0]];

  // A pop at the end of STOP chains the next character with no idle gap.
  wire tx_pop      = tx_en && !tx_empty && (tx_state == S_IDLE || (tx_state == S_STOP && tx_tc));
  wire tx_push_req = wr_en && sel == 2'd0;
  wire tx_push_ok  = tx_push_req && (!tx_full || tx_pop);
  wire rx_pop      = rd_en && sel == 2'd0 && !rx_empty;
  wire rx_push_req = rx_state == S_STOP && rx_tc;
  wire rx_push_ok  = rx_push_req && (!rx_full || rx_pop);
  wire rx_par_bad  = rx_state == S_PARITY && rx_tc && (rx_s2 != ((^rx_sh) ^ par_odd));
  wire rx_frm_bad  = rx_push_req && !rx_s2;

`ifdef UART_APB_FIFO_LOOPBACK_EN
  assign rx_src = ctrl[8] ? tx_line : rxd;
  assign txd    = ctrl[8] ? 1'b1 : tx_line;
`else
  assign rx_src = rxd;
  assign txd    = tx_line;
`endif

  assign PREADY  = 1'b1;
  assign PSLVERR = acc & ~addr_ok;

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (sel)
        2'd0: if (!rx_empty) PRDATA[DATA_BITS-1:0] = rx_head;
        2'd1: PRDATA[8:0] = {tx_ovf, overrun, parity_err, frame_err, tx_busy,
                             tx_full, tx_empty, rx_full, !rx_empty};
        2'd2: PRDATA[CTRL_W-1:0] = ctrl;
        2'd3: PRDATA[DIV_W-1:0] = div_q;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push_ok) tx_mem[tx_wp[AW-1:0]] <= PWDATA[DATA_BITS-1:0];
    if (rx_push_ok) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl <= '0; div_q <= '0; baud_cnt <= '0;
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      frame_err <= 1'b0; parity_err <= 1'b0; overrun <= 1'b0; tx_ovf <= 1'b0;
      irqreq <= 1'b0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_s3 <= 1'b1;
    end else begin
      if (wr_en && sel == 2'd2) ctrl  <= PWDATA[CTRL_W-1:0];
      if (wr_en && sel == 2'd3) div_q <= PWDATA[DIV_W-1:0];
      if (wr_en && sel == 2'd3) baud_cnt <= '0;
      else if (tick)            baud_cnt <= '0;
      else                      baud_cnt <= baud_cnt + DIV_W'(1);
      if (tx_push_ok) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)     tx_rp <= tx_rp + PTR_ONE;
      if (rx_push_ok) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)     rx_rp <= rx_rp + PTR_ONE;
      // A flag raised in the same cycle as a STATUS read survives to the next read.
      frame_err  <= (frame_err  & ~stat_rd) | rx_frm_bad;
      parity_err <= (parity_err & ~stat_rd) | rx_par_bad;
      overrun    <= (overrun    & ~stat_rd) | (rx_push_req && !rx_push_ok);
      tx_ovf     <= (tx_ovf     & ~stat_rd) | (tx_push_req && !tx_push_ok);
      irqreq <= (ie_rx & !rx_empty) | (ie_tx & tx_empty) |
                (ie_err & (frame_err | parity_err | overrun | tx_ovf));
      rx_s1 <= rx_src; rx_s2 <= rx_s1; rx_s3 <= rx_s2;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state <= S_IDLE; tx_tcnt <= '0; tx_bit <= '0; tx_sh <= '0; tx_par <= 1'b0; tx_line <= 1'b1;
    end else begin
      if (tx_pop) begin
        tx_sh <= tx_head; tx_par <= (^tx_head) ^ par_odd;
        tx_line <= 1'b0; tx_tcnt <= 5'd15; tx_state <= S_START;
      end else if (tick) begin
        tx_tcnt <= tx_tcnt - 5'd1;
        if (tx_tcnt == 5'd0) begin
          tx_tcnt <= 5'd15;
          case (tx_state)
            S_START: begin tx_state <= S_DATA; tx_line <= tx_sh[0]; tx_bit <= '0; end
            S_DATA:
              if (tx_bit != LAST_BIT) begin
                tx_bit <= tx_bit + 4'd1; tx_sh <= tx_sh >> 1; tx_line <= tx_sh[1];
              end else if (par_en) begin
                tx_state <= S_PARITY; tx_line <= tx_par;
              end else begin
                tx_state <= S_STOP; tx_line <= 1'b1; tx_tcnt <= stop2 ? 5'd31 : 5'd15;
              end
            S_PARITY: begin tx_state <= S_STOP; tx_line <= 1'b1; tx_tcnt <= stop2 ? 5'd31 : 5'd15; end
            S_STOP:   begin tx_state <= S_IDLE; tx_line <= 1'b1; end
            default:  begin tx_state <= S_IDLE; tx_line <= 1'b1; end
          endcase
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_state <= S_IDLE; rx_tcnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else if (rx_state == S_IDLE) begin
      if (rx_en && rx_s3 && !rx_s2) begin rx_state <= S_START; rx_tcnt <= 4'd7; end
    end else if (tick) begin
      rx_tcnt <= rx_tcnt - 4'd1;
      if (rx_tcnt == 4'd0) begin
        rx_tcnt <= 4'd15;
        case (rx_state)
          S_START: if (rx_s2) rx_state <= S_IDLE;
                   else begin rx_state <= S_DATA; rx_bit <= '0; end
          S_DATA: begin
            rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit == LAST_BIT) rx_state <= par_en ? S_PARITY : S_STOP;
          end
          S_PARITY: rx_state <= S_STOP;
          default:  rx_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_apb_fifo.sv
// Randomized self-checking bench for uart_apb_fifo; expected frames, FIFO contents and flags come from queue models.
module tb_uart_apb_fifo;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, rxd = 1'b1;
  logic        PREADY, PSLVERR, irqreq, txd;
  logic [31:0] PRDATA;
  int          n_chk = 0, n_err = 0;

  uart_apb_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .irqreq(irqreq), .rxd(rxd), .txd(txd));

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK); PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK); PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic bit even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Waits for a start bit, then samples every bit at mid-bit (bit time 32 PCLK at DIV=1).
  task automatic tx_frame(input string tag, input logic [7:0] d, input bit pe, input bit po,
                          input bit s2, output int gap);
    bit fr[$];
    logic [15:0] exp_w, obs_w;
    fr.push_back(1'b0);
    for (int i = 0; i < 8; i++) fr.push_back(d[i]);
    if (pe) fr.push_back(even_par(d) ^ po);
    fr.push_back(1'b1);
    if (s2) fr.push_back(1'b1);
    exp_w = '0; obs_w = '0; gap = 0;
    while (txd !== 1'b0 && gap < 2000) begin @(negedge PCLK); gap++; end
    if (txd !== 1'b0) begin check_val({tag, "_start"}, 32'(txd), 32'h0); return; end
    repeat (16) @(negedge PCLK);
    foreach (fr[i]) begin
      if (i > 0) repeat (32) @(negedge PCLK);
      obs_w[i] = txd; exp_w[i] = fr[i];
    end
    check_val(tag, 32'(obs_w), 32'(exp_w));
  endtask

  task automatic rx_send(input logic [7:0] d, input bit pe, input bit po, input bit bad,
                         input logic stop_v);
    bit fr[$];
    fr.push_back(1'b0);
    for (int i = 0; i < 8; i++) fr.push_back(d[i]);
    if (pe) fr.push_back(even_par(d) ^ po ^ bad);
    fr.push_back(stop_v);
    foreach (fr[i]) begin rxd = fr[i]; repeat (32) @(negedge PCLK); end
    rxd = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [7:0]  q[$];
    logic [7:0]  d;
    bit          pe, po, s2, bad, lo;
    int          gap;

    repeat (2) @(posedge PCLK);
    @(negedge PCLK); PRESET = 1'b0;
    check_val("rst_txd", 32'(txd), 32'h1);
    check_val("rst_irq", 32'(irqreq), 32'h0);
    check_val("rst_prdata", PRDATA, 32'h0);
    check_val("pready", 32'(PREADY), 32'h1);
    apb_rd(32'h4, rd, err);
    check_val("rst_status", rd, 32'h4);
    check_val("rst_pslverr", 32'(err), 32'h0);

    apb_wr(32'hC, 32'h12345);
    apb_rd(32'hC, rd, err);
    check_val("div_rb", rd, 32'h2345);
    apb_wr(32'h8, 32'h1FF);
    @(negedge PCLK);
    apb_rd(32'h8, rd, err);
`ifdef UART_APB_FIFO_LOOPBACK_EN
    check_val("ctrl_rb", rd, 32'h1FF);
`else
    check_val("ctrl_rb", rd, 32'hFF);
`endif
    check_val("irq_tx_empty", 32'(irqreq), 32'h1);
    apb_wr(32'h8, 32'h0);
    apb_wr(32'hC, 32'h1);

    apb_wr(32'h8, 32'h1);
    apb_wr(32'h0, 32'hA5);
    tx_frame("tx_a5", 8'hA5, 1'b0, 1'b0, 1'b0, gap);
    repeat (24) @(negedge PCLK);
    apb_rd(32'h4, rd, err);
    check_val("tx_done_status", rd, 32'h4);

    apb_wr(32'h8, 32'h1D);
    apb_wr(32'h0, 32'h03);
    tx_frame("tx_03_par_stop2", 8'h03, 1'b1, 1'b1, 1'b1, gap);
    apb_rd(32'h4, rd, err);
    check_val("tx_stop2_busy", rd & 32'h10, 32'h10);
    repeat (40) @(negedge PCLK);

    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
      apb_wr(32'h8, 32'h1 | (32'(pe) << 2) | (32'(po) << 3) | (32'(s2) << 4));
      apb_wr(32'h0, 32'(d));
      tx_frame($sformatf("tx_rand%0d", k), d, pe, po, s2, gap);
      repeat (60) @(negedge PCLK);
    end

    apb_wr(32'h8, 32'h0);
    q = {};
    for (int k = 0; k < 17; k++) begin
      d = 8'($urandom);
      if (k < 16) q.push_back(d);
      apb_wr(32'h0, 32'(d));
    end
    apb_rd(32'h4, rd, err);
    check_val("tx_full_ovf", rd, 32'h108);
    apb_wr(32'h8, 32'h1);
    for (int k = 0; k < 16; k++) begin
      tx_frame($sformatf("tx_fifo%0d", k), q[k], 1'b0, 1'b0, 1'b0, gap);
      if (k > 0) check_val($sformatf("tx_b2b_gap%0d", k), 32'(gap <= 20), 32'h1);
    end
    lo = 1'b0;
    repeat (600) begin @(negedge PCLK); if (txd === 1'b0) lo = 1'b1; end
    check_val("tx_no_extra", 32'(lo), 32'h0);
    apb_rd(32'h4, rd, err);
    check_val("tx_drained", rd, 32'h4);

    apb_wr(32'h8, 32'h22);
    rx_send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rx_irq_rise", 32'(irqreq), 32'h1);
    apb_rd(32'h0, rd, err);
    check_val("rx_5a", rd, 32'h5A);
    apb_rd(32'h4, rd, err);
    check_val("rx_after_pop", rd, 32'h4);
    check_val("rx_irq_fall", 32'(irqreq), 32'h0);

    apb_wr(32'h8, 32'h02);
    rx_send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    apb_rd(32'h4, rd, err);
    check_val("frame_err_set", rd, 32'h25);
    apb_rd(32'h4, rd, err);
    check_val("frame_err_clr", rd, 32'h5);
    apb_rd(32'h0, rd, err);
    check_val("frame_err_data", rd, 32'h3C);
    apb_rd(32'h0, rd, err);
    check_val("rx_empty_read", rd, 32'h0);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); bad = pe & 1'($urandom);
      apb_wr(32'h8, 32'h2 | (32'(pe) << 2) | (32'(po) << 3));
      rx_send(d, pe, po, bad, 1'b1);
      apb_rd(32'h0, rd, err);
      check_val($sformatf("rx_rand%0d", k), rd, 32'(d));
      apb_rd(32'h4, rd, err);
      check_val($sformatf("rx_rand_status%0d", k), rd, 32'h4 | (32'(bad) << 6));
    end

    apb_wr(32'h8, 32'h02);
    q = {};
    for (int k = 0; k < 17; k++) begin
      d = 8'($urandom);
      if (k < 16) q.push_back(d);
      rx_send(d, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    apb_rd(32'h4, rd, err);
    check_val("rx_overrun", rd, 32'h87);
    for (int k = 0; k < 16; k++) begin
      apb_rd(32'h0, rd, err);
      check_val($sformatf("rx_fifo%0d", k), rd, 32'(q[k]));
    end
    apb_rd(32'h4, rd, err);
    check_val("rx_drained", rd, 32'h4);

    apb_wr(32'h18, 32'hFF);
    apb_wr(32'h1C, 32'h7);
    apb_rd(32'h10, rd, err);
    check_val("slverr_flag", 32'(err), 32'h1);
    check_val("slverr_data", rd, 32'h0);
    apb_rd(32'h8, rd, err);
    check_val("slverr_ctrl_kept", rd, 32'h2);
    apb_rd(32'hC, rd, err);
    check_val("slverr_div_kept", rd, 32'h1);

`ifdef UART_APB_FIFO_LOOPBACK_EN
    apb_wr(32'h8, 32'h103);
    apb_wr(32'h0, 32'h3C);
    lo = 1'b0;
    repeat (400) begin @(negedge PCLK); if (txd === 1'b0) lo = 1'b1; end
    check_val("lb_txd_idle", 32'(lo), 32'h0);
    apb_rd(32'h0, rd, err);
    check_val("lb_data", rd, 32'h3C);
`endif

    apb_wr(32'h8, 32'h1);
    apb_wr(32'h0, 32'h00);
    repeat (100) @(negedge PCLK);
    check_val("midframe_low", 32'(txd), 32'h0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_val("midframe_rst_txd", 32'(txd), 32'h1);
    PRESET = 1'b0;
    apb_rd(32'h4, rd, err);
    check_val("midframe_rst_status", rd, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
